// File: rtl/sokoban_move_engine.sv
// Sokoban move engine: walk and box-push as read-modify-write sequences on the shared board RAM.
// Optional AUTO_REPEAT_EN: a held button re-issues its command every REPEAT_TICKS ticks.
module sokoban_move_engine #(
    parameter int unsigned COLS         = 10,
    parameter int unsigned ROWS         = 8,
    parameter int unsigned PLAYER_X0    = 1,
    parameter int unsigned PLAYER_Y0    = 3,
    parameter logic [79:0] GOAL_MASK    = (80'd1 << 42) | (80'd1 << 43) |
                                          (80'd1 << 52) | (80'd1 << 53),
    parameter int unsigned NUM_GOALS    = 4,
    parameter int unsigned REPEAT_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_n,
    input  logic        tick,
    output logic [3:0]  rd_x,
    output logic [2:0]  rd_y,
    input  logic [2:0]  rd_data,
    output logic        wr_en,
    output logic [3:0]  wr_x,
    output logic [2:0]  wr_y,
    output logic [2:0]  wr_data,
    output logic [3:0]  player_x,
    output logic [2:0]  player_y,
    output logic [15:0] moves,
    output logic        success,
    output logic        busy
);
    localparam logic [2:0] CellRoad   = 3'd0;
    localparam logic [2:0] CellWall   = 3'd1;
    localparam logic [2:0] CellPlayer = 3'd2;
    localparam logic [2:0] CellBox    = 3'd3;
    localparam logic [2:0] CellDot    = 3'd4;

    typedef enum logic [2:0] {
        StIdle, StRdT, StRdB, StDec, StWrBox, StWrOld, StWrNew
    } state_t;

    state_t             state;
    logic [3:0]         t_x_q, b_x_q;
    logic [2:0]         t_y_q, b_y_q;
    logic               b_out_q;
    logic [2:0]         tgt;
    logic [2:0]         on_goal;
    logic               single, t_ok, b_ok, cmd_ok, accept;
    logic signed [5:0]  dx, dy, t_x, t_y, b_x, b_y;
    logic [2:0]         bey;

    function automatic logic goal_at(input logic [3:0] x, input logic [2:0] y);
        logic [6:0] idx;
        idx = 7'(int'(y) * int'(COLS) + int'(x));
        return (idx < 7'd80) ? GOAL_MASK[idx] : 1'b0;
    endfunction

    always_comb begin
        single = 1'b1;
        dx     = '0;
        dy     = '0;
        case (btn_n)
            4'b1110: dy = -6'sd1;
            4'b1101: dx = -6'sd1;
            4'b1011: dy = 6'sd1;
            4'b0111: dx = 6'sd1;
            default: single = 1'b0;
        endcase
        t_x  = $signed({2'b00, player_x}) + dx;
        t_y  = $signed({3'b000, player_y}) + dy;
        b_x  = t_x + dx;
        b_y  = t_y + dy;
        t_ok = !t_x[5] && !t_y[5] && (t_x < 6'(COLS)) && (t_y < 6'(ROWS));
        b_ok = !b_x[5] && !b_y[5] && (b_x < 6'(COLS)) && (b_y < 6'(ROWS));
    end

    // A beyond-cell off the board behaves exactly like a wall.
    assign bey    = b_out_q ? CellWall : rd_data;
    assign accept = (state == StIdle) && tick && single && cmd_ok;

`ifdef AUTO_REPEAT_EN
    logic [3:0]  last_btn;
    logic        fresh;
    logic [15:0] rep_cnt;
    logic        btn_changed;

    assign btn_changed = (btn_n != last_btn);
    assign cmd_ok      = fresh || btn_changed || (rep_cnt == 16'(REPEAT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_btn <= 4'hF;
            fresh    <= 1'b1;
            rep_cnt  <= '0;
        end else begin
            last_btn <= btn_n;
            if (accept) begin
                fresh   <= 1'b0;
                rep_cnt <= '0;
            end else if (btn_changed) begin
                fresh   <= 1'b1;
                rep_cnt <= '0;
            end else if ((state == StIdle) && tick && single) begin
                rep_cnt <= rep_cnt + 16'd1;
            end
        end
    end
`else
    logic armed;

    assign cmd_ok = armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
        end else if (btn_n == 4'hF) begin
            armed <= 1'b1;
        end else if (accept) begin
            armed <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            player_x <= 4'(PLAYER_X0);
            player_y <= 3'(PLAYER_Y0);
            moves    <= '0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            success  <= 1'b0;
            on_goal  <= '0;
            rd_x     <= '0;
            rd_y     <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
            t_x_q    <= '0;
            t_y_q    <= '0;
            b_x_q    <= '0;
            b_y_q    <= '0;
            b_out_q  <= 1'b0;
            tgt      <= '0;
        end else begin
            wr_en   <= 1'b0;
            success <= (on_goal == 3'(NUM_GOALS));
            unique case (state)
                StIdle: begin
                    if (accept && t_ok) begin
                        t_x_q   <= t_x[3:0];
                        t_y_q   <= t_y[2:0];
                        b_x_q   <= b_x[3:0];
                        b_y_q   <= b_y[2:0];
                        b_out_q <= !b_ok;
                        rd_x    <= t_x[3:0];
                        rd_y    <= t_y[2:0];
                        busy    <= 1'b1;
                        state   <= StRdT;
                    end
                end
                StRdT: begin
                    rd_x  <= b_x_q;
                    rd_y  <= b_y_q;
                    state <= StRdB;
                end
                StRdB: begin
                    tgt   <= rd_data;
                    state <= StDec;
                end
                StDec: begin
                    if (tgt == CellRoad || tgt == CellDot) begin
                        wr_en   <= 1'b1;
                        wr_x    <= player_x;
                        wr_y    <= player_y;
                        wr_data <= goal_at(player_x, player_y) ? CellDot : CellRoad;
                        state   <= StWrOld;
                    end else if (tgt == CellBox && (bey == CellRoad || bey == CellDot)) begin
                        wr_en   <= 1'b1;
                        wr_x    <= b_x_q;
                        wr_y    <= b_y_q;
                        wr_data <= CellBox;
                        state   <= StWrBox;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StWrBox: begin
                    on_goal <= on_goal + {2'b00, goal_at(b_x_q, b_y_q)}
                                       - {2'b00, goal_at(t_x_q, t_y_q)};
                    wr_en   <= 1'b1;
                    wr_x    <= player_x;
                    wr_y    <= player_y;
                    wr_data <= goal_at(player_x, player_y) ? CellDot : CellRoad;
                    state   <= StWrOld;
                end
                StWrOld: begin
                    wr_en   <= 1'b1;
                    wr_x    <= t_x_q;
                    wr_y    <= t_y_q;
                    wr_data <= CellPlayer;
                    state   <= StWrNew;
                end
                StWrNew: begin
                    player_x <= t_x_q;
                    player_y <= t_y_q;
                    if (moves != 16'hFFFF) moves <= moves + 16'd1;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
